rom_stream_reader: RTL and testbench
====================================

// Module: rom_stream_reader
// PURPOSE
//  Initiator side of the 8-bit async-read ROM interface (address/read_en/ce -> data).
//  On start, fetches a block of LEN bytes from START_ADDR, one per cycle.
//  Presents the bytes on a valid/ready stream with full throughput and backpressure.
//  Sits between a control FSM and a combinational lookup ROM, feeding a byte consumer.
// PARAMETERS
//  AW  8  ROM address width; the address counter wraps modulo 2**AW
//  DW  8  ROM/stream data width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  start        in   1       request a block fetch; sampled only in IDLE
//  start_addr   in   AW      first ROM address of the block
//  length       in   AW      byte count; 0 means 2**AW bytes
//  abort        in   1       synchronous cancel of the current block
//  busy         out  1       high while state != IDLE
//  done         out  1       1-cycle pulse after the last byte is accepted
//  rom_address  out  AW      ROM address
//  rom_read_en  out  1       high only in fetch cycles
//  rom_ce       out  1       high throughout RUN
//  rom_data     in   DW      combinational ROM data for rom_address
//  out_data     out  DW      registered stream data
//  out_valid    out  1       stream valid
//  out_ready    in   1       stream ready
//  chksum       out  DW      only with ROM_RDR_CHKSUM_EN
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, out_valid, rom_read_en, rom_ce = 0; out_data, rom_address = 0.
//  Internal regs: addr_q[AW-1:0]; remain_q[AW:0], wide enough to hold 2**AW.
//  FSM IDLE: start=1 -> addr_q=start_addr; remain_q=(length==0 ? 2**AW : length); go RUN.
//  FSM RUN: rom_ce=1; rom_address=addr_q (combinational from addr_q).
//   fetch = remain_q!=0 && (!out_valid || out_ready); rom_read_en = fetch.
//   fetch: out_data<=rom_data, out_valid<=1, addr_q<=addr_q+1 (wraps to 0), remain_q<=remain_q-1.
//   out_ready && !fetch: out_valid<=0.
//   remain_q==0 && (!out_valid || out_ready): go IDLE, done<=1 for one cycle.
//  Handshake: a byte transfers on out_valid&&out_ready. out_data and out_valid are held stable while !out_ready.
//  Latency: first out_valid is 2 cycles after the start cycle (IDLE->RUN, then the fetch cycle).
//   After that, one byte per cycle while out_ready=1.
//  Start is ignored while busy; back-to-back blocks need one IDLE cycle between them.
//  abort (any state): next cycle IDLE, out_valid=0, remain_q=0; no done pulse; abort beats fetch.
//  Simultaneous start+abort in IDLE: abort wins, and the FSM stays in IDLE.
//  reset_n low mid-block: immediate return to reset values; the in-flight byte is lost.
// CONFIGURATION
//  ROM_RDR_CHKSUM_EN defined:
//   chksum port exists; the register clears on start.
//   Each fetched byte is XORed into the register.
//   The register is final and stable when done pulses, and holds until the next start.
//  Undefined: no chksum port or register; all other behaviour is identical.
// TESTING
//  Bench ROM model contents: a0=8'h0A, a1=8'h37, a2=8'hF4, a3=8'h00, a255=8'h5A; all other addresses = address.
//  T1 stream: start_addr=0, length=4, out_ready=1
//   -> out_data 0A,37,F4,00 on 4 consecutive cycles; done 1 cycle after the last handshake; busy then 0.
//  T2 backpressure: T1 with out_ready toggled 1,0,0,1,...
//   -> no byte lost or duplicated; data held while ready=0; rom_read_en=0 in stalled cycles.
//  T3 wrap/zero length:
//   start_addr=255, length=2 -> rom_address 255 then 0; bytes 5A,0A.
//   length=0 -> exactly 256 handshakes, then done.
//  T4 abort/reset:
//   abort after the 2nd byte of T1 -> out_valid=0 next cycle, no done; a new start works.
//   reset_n=0 mid-block -> all outputs at reset values.
//  T5 chksum (ROM_RDR_CHKSUM_EN): T1 -> chksum=8'hC9 at done; the next start clears it to 0.

Source files
------------

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: fetches a block of bytes from a combinational lookup ROM
// and presents them on a valid/ready byte stream. The stream runs at full
// throughput and honours backpressure from the consumer.
// Optional feature macro: ROM_RDR_CHKSUM_EN adds an XOR checksum of every
// fetched byte on the chksum port.
module rom_stream_reader #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_address,
  output logic          rom_read_en,
  output logic          rom_ce,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef ROM_RDR_CHKSUM_EN
  ,
  output logic [DW-1:0] chksum
`endif
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW:0]   remain_q;
  logic          can_advance;
  logic          fetch;
  logic [AW:0]   block_len;

  // The output register can take a new byte when it is empty or being drained.
  assign can_advance = !out_valid || out_ready;

  // A fetch moves one ROM byte into the output register; abort always wins.
  assign fetch = (state == RUN) && (remain_q != '0) && can_advance && !abort;

  // A length of zero stands for a full 2**AW byte block.
  assign block_len = (length == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, length};

  assign rom_address = addr_q;
  assign rom_read_en = fetch;
  assign rom_ce      = (state == RUN);
  assign busy        = (state != IDLE);

  // Control FSM, address/remaining counters and the registered stream output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        remain_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              addr_q   <= start_addr;
              remain_q <= block_len;
              state    <= RUN;
            end
          end
          RUN: begin
            if (fetch) begin
              out_data  <= rom_data;
              out_valid <= 1'b1;
              addr_q    <= addr_q + 1'b1;
              remain_q  <= remain_q - 1'b1;
            end else if (out_ready) begin
              out_valid <= 1'b0;
            end
            if ((remain_q == '0) && can_advance) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ROM_RDR_CHKSUM_EN
  // Running XOR of fetched bytes, cleared when a new block is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chksum <= '0;
    end else if (!abort && (state == IDLE) && start) begin
      chksum <= '0;
    end else if (fetch) begin
      chksum <= chksum ^ rom_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader: cycle tables for the basic and stalled
// stream, hand-written sequences for wrap, abort and reset, and randomized
// blocks checked against a queue of expected bytes.
// Define ROM_RDR_CHKSUM_EN to also check the checksum output.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] length;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] rom_address;
  logic       rom_read_en;
  logic       rom_ce;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef ROM_RDR_CHKSUM_EN
  logic [7:0] chksum;
`endif

  int checks = 0;
  int errors = 0;

  rom_stream_reader #(.AW(8), .DW(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_read_en (rom_read_en),
    .rom_ce      (rom_ce),
    .rom_data    (rom_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef ROM_RDR_CHKSUM_EN
    ,
    .chksum      (chksum)
`endif
  );

  always #5 clk = ~clk;

  // Lookup ROM contents used by the bench.
  function automatic logic [7:0] rom_model(input logic [7:0] a);
    case (a)
      8'd0:    return 8'h0A;
      8'd1:    return 8'h37;
      8'd2:    return 8'hF4;
      8'd3:    return 8'h00;
      8'd255:  return 8'h5A;
      default: return a;
    endcase
  endfunction

  assign rom_data = rom_model(rom_address);

  typedef struct packed {
    logic       start;
    logic       ready;
    logic       exp_ce;
    logic       exp_rd;
    logic [7:0] exp_addr;
    logic       exp_busy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic ce, input logic rd,
                              input logic [7:0] ad, input logic b, input logic v,
                              input logic [7:0] d, input logic dn);
    vec_t x;
    x.start = s; x.ready = r; x.exp_ce = ce; x.exp_rd = rd; x.exp_addr = ad;
    x.exp_busy = b; x.exp_valid = v; x.exp_data = d; x.exp_done = dn;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic ab, input logic r,
                                input logic [7:0] sa, input logic [7:0] len);
    start      = s;
    abort      = ab;
    out_ready  = r;
    start_addr = sa;
    length     = len;
  endtask

  // Randomized block checked against the list of bytes the block must deliver.
  task automatic run_random_block(input logic [7:0] sa, input logic [7:0] len, input bit do_abort);
    logic [7:0] exp_q[$];
    logic [7:0] exp_sum;
    logic [7:0] prev_data;
    logic [7:0] a;
    int n, hs_count, abort_at, cyc;
    bit finished, expect_done, aborted, prev_stall, ready_now;
    n = (len == 8'd0) ? 256 : int'(len);
    exp_sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      a = sa + 8'(i);
      exp_q.push_back(rom_model(a));
      exp_sum = exp_sum ^ rom_model(a);
    end
    abort_at = do_abort ? int'($urandom_range(0, 2 * n)) : -1;
    hs_count = 0; cyc = 0; finished = 0; expect_done = 0; aborted = 0;
    prev_stall = 0; prev_data = 8'h00;
    apply_stimulus(1'b1, 1'b0, 1'b1, sa, len);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, sa, len);
`ifdef ROM_RDR_CHKSUM_EN
    check_output("blk.chksum_clear", chksum, 8'h00);
`endif
    while (!finished && cyc < 4 * n + 20) begin
      if (expect_done || aborted) begin
        check_output("blk.done", done, !aborted);
        check_output("blk.busy_end", busy, 1'b0);
        check_output("blk.valid_end", out_valid, 1'b0);
        if (expect_done) begin
          check_output("blk.count", hs_count, n);
`ifdef ROM_RDR_CHKSUM_EN
          check_output("blk.chksum", chksum, exp_sum);
`endif
        end
        finished = 1;
      end else begin
        check_output("blk.done_early", done, 1'b0);
        check_output("blk.busy", busy, 1'b1);
        if (prev_stall) begin
          check_output("blk.hold_valid", out_valid, 1'b1);
          check_output("blk.hold_data", out_data, prev_data);
        end
        ready_now = ($urandom_range(0, 2) != 0);
        if (cyc == abort_at) begin
          apply_stimulus(1'b0, 1'b1, ready_now, sa, len);
          aborted = 1;
        end else begin
          apply_stimulus(1'b0, 1'b0, ready_now, sa, len);
          if (out_valid && ready_now) begin
            check_output("blk.extra_byte", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              check_output("blk.data", out_data, exp_q.pop_front());
              hs_count++;
              if (exp_q.size() == 0) expect_done = 1;
            end
          end
          prev_stall = out_valid && !ready_now;
          prev_data  = out_data;
        end
        cyc++;
        @(negedge clk);
      end
    end
    if (!finished) check_output("blk.timeout", 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, sa, len);
    @(negedge clk);
    check_output("blk.done_once", done, 1'b0);
  endtask

  vec_t vecs[20];

  // Main test sequence.
  initial begin
    vecs[0]  = mk(1, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 1, 1, 8'h00, 1, 1, 8'h0A, 0);
    vecs[2]  = mk(0, 1, 1, 1, 8'h01, 1, 1, 8'h37, 0);
    vecs[3]  = mk(0, 1, 1, 1, 8'h02, 1, 1, 8'hF4, 0);
    vecs[4]  = mk(0, 1, 1, 1, 8'h03, 1, 1, 8'h00, 0);
    vecs[5]  = mk(0, 1, 1, 0, 8'h04, 0, 0, 8'h00, 1);
    vecs[6]  = mk(0, 1, 0, 0, 8'h04, 0, 0, 8'h00, 0);
    vecs[7]  = mk(1, 1, 0, 0, 8'h04, 1, 0, 8'h00, 0);
    vecs[8]  = mk(0, 1, 1, 1, 8'h00, 1, 1, 8'h0A, 0);
    vecs[9]  = mk(0, 0, 1, 0, 8'h01, 1, 1, 8'h0A, 0);
    vecs[10] = mk(0, 0, 1, 0, 8'h01, 1, 1, 8'h0A, 0);
    vecs[11] = mk(0, 1, 1, 1, 8'h01, 1, 1, 8'h37, 0);
    vecs[12] = mk(0, 0, 1, 0, 8'h02, 1, 1, 8'h37, 0);
    vecs[13] = mk(0, 0, 1, 0, 8'h02, 1, 1, 8'h37, 0);
    vecs[14] = mk(0, 1, 1, 1, 8'h02, 1, 1, 8'hF4, 0);
    vecs[15] = mk(0, 0, 1, 0, 8'h03, 1, 1, 8'hF4, 0);
    vecs[16] = mk(0, 1, 1, 1, 8'h03, 1, 1, 8'h00, 0);
    vecs[17] = mk(0, 0, 1, 0, 8'h04, 1, 1, 8'h00, 0);
    vecs[18] = mk(0, 1, 1, 0, 8'h04, 0, 0, 8'h00, 1);
    vecs[19] = mk(0, 0, 0, 0, 8'h04, 0, 0, 8'h00, 0);

    reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check_output("rst.busy", busy, 1'b0);
    check_output("rst.done", done, 1'b0);
    check_output("rst.valid", out_valid, 1'b0);
    check_output("rst.read_en", rom_read_en, 1'b0);
    check_output("rst.ce", rom_ce, 1'b0);
    check_output("rst.data", out_data, 8'h00);
    check_output("rst.address", rom_address, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // T1 full-rate stream followed by T2 with backpressure.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].start, 1'b0, vecs[i].ready, 8'h00, 8'd4);
      #1;
      check_output($sformatf("vec%0d.ce", i), rom_ce, vecs[i].exp_ce);
      check_output($sformatf("vec%0d.read_en", i), rom_read_en, vecs[i].exp_rd);
      check_output($sformatf("vec%0d.address", i), rom_address, vecs[i].exp_addr);
      @(negedge clk);
      check_output($sformatf("vec%0d.busy", i), busy, vecs[i].exp_busy);
      check_output($sformatf("vec%0d.valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check_output($sformatf("vec%0d.data", i), out_data, vecs[i].exp_data);
      check_output($sformatf("vec%0d.done", i), done, vecs[i].exp_done);
`ifdef ROM_RDR_CHKSUM_EN
      if (i == 5 || i == 18) check_output($sformatf("vec%0d.chksum", i), chksum, 8'hC9);
      if (i == 7) check_output("vec7.chksum_clear", chksum, 8'h00);
`endif
    end

    // T3 address wrap from 255 to 0.
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'd2);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'd2);
    #1;
    check_output("wrap.addr0", rom_address, 8'hFF);
    check_output("wrap.read_en", rom_read_en, 1'b1);
    @(negedge clk);
    check_output("wrap.data0", out_data, 8'h5A);
    check_output("wrap.addr1", rom_address, 8'h00);
    @(negedge clk);
    check_output("wrap.data1", out_data, 8'h0A);
    @(negedge clk);
    check_output("wrap.done", done, 1'b1);
    check_output("wrap.busy", busy, 1'b0);

    // T3 zero length means a full 256-byte block.
    run_random_block(8'h80, 8'd0, 1'b0);

    // T4 abort after the second byte, then a fresh block.
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'd4);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'd4);
    @(negedge clk);
    @(negedge clk);
    check_output("abort.second", out_data, 8'h37);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'd4);
    #1;
    check_output("abort.no_fetch", rom_read_en, 1'b0);
    @(negedge clk);
    check_output("abort.valid", out_valid, 1'b0);
    check_output("abort.busy", busy, 1'b0);
    check_output("abort.done", done, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'd4);
    @(negedge clk);
    check_output("abort.done_later", done, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h40, 8'd2);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h40, 8'd2);
    @(negedge clk);
    check_output("restart.data0", out_data, 8'h40);
    check_output("restart.valid", out_valid, 1'b1);
    @(negedge clk);
    check_output("restart.data1", out_data, 8'h41);
    @(negedge clk);
    check_output("restart.done", done, 1'b1);

    // Simultaneous start and abort in IDLE stays in IDLE.
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'd4);
    @(negedge clk);
    check_output("startabort.busy", busy, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'd4);
    @(negedge clk);
    check_output("startabort.busy2", busy, 1'b0);
    check_output("startabort.valid", out_valid, 1'b0);

    // Reset in the middle of a stalled block.
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'd4);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'd4);
    repeat (2) @(negedge clk);
    check_output("midrst.valid_before", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check_output("midrst.busy", busy, 1'b0);
    check_output("midrst.valid", out_valid, 1'b0);
    check_output("midrst.data", out_data, 8'h00);
    check_output("midrst.address", rom_address, 8'h00);
    check_output("midrst.ce", rom_ce, 1'b0);
    check_output("midrst.read_en", rom_read_en, 1'b0);
    check_output("midrst.done", done, 1'b0);
`ifdef ROM_RDR_CHKSUM_EN
    check_output("midrst.chksum", chksum, 8'h00);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("midrst.idle", busy, 1'b0);

    // Randomized blocks, some of them aborted part way.
    for (int b = 0; b < 16; b++) begin
      run_random_block(8'($urandom), 8'($urandom_range(1, 12)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a run that never reaches its end.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
